// File: rtl/fifo_stream_reader.sv
// Read-side controller for a 512x40 synchronous FIFO, presented as a valid/ready stream.
// Optional transfer counter (output word_cnt) is enabled by defining FIFO_RDR_WORD_COUNT_EN.
module fifo_stream_reader #(
    parameter int DW   = 40,
    parameter int SKID = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          fifo_clr,
    input  logic          fifo_empty,
    output logic          fifo_re,
    input  logic [DW-1:0] fifo_dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          busy
`ifdef FIFO_RDR_WORD_COUNT_EN
    ,
    output logic [31:0]   word_cnt
`endif
);

    logic          pend_q, pend_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [1:0]    cntAfter;
    logic [DW-1:0] buf0_q, buf0_d;
    logic [DW-1:0] buf1_q, buf1_d;
    logic          popOut;
    logic [2:0]    occ;

    assign m_valid  = (cnt_q != 2'd0);
    assign m_data   = buf0_q;
    assign popOut   = m_valid & m_ready;
    assign fifo_clr = clr;
    assign busy     = m_valid | pend_q | !fifo_empty;

    // Every in-flight read already owns a skid slot, so pops never over-commit.
    assign occ     = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, popOut};
    assign fifo_re = !rst & !clr & !fifo_empty & (occ < 3'd2);

    always_comb begin
        cntAfter = cnt_q - {1'b0, popOut};
        pend_d   = fifo_re;
        cnt_d    = cntAfter + {1'b0, pend_q};
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        if (popOut && (cnt_q == 2'd2)) begin
            buf0_d = buf1_q;
        end
        if (pend_q) begin
            if (cntAfter == 2'd0) begin
                buf0_d = fifo_dout;
            end else begin
                buf1_d = fifo_dout;
            end
        end
        if (clr) begin
            pend_d = 1'b0;
            cnt_d  = 2'd0;
            buf0_d = buf0_q;
            buf1_d = buf1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            cnt_q  <= 2'd0;
            buf0_q <= '0;
            buf1_q <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
        end
    end

`ifdef FIFO_RDR_WORD_COUNT_EN
    logic [31:0] word_cnt_q, word_cnt_d;

    always_comb begin
        word_cnt_d = word_cnt_q + {31'd0, popOut};
        if (clr) begin
            word_cnt_d = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_q <= 32'd0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

    // The head word may not change while the consumer is stalling it.
    property pHoldData;
        @(posedge clk) disable iff (rst)
            (m_valid && !m_ready && !clr) |=> $stable(m_data);
    endproperty
    aHoldData: assert property (pHoldData);

    property pOccupancy;
        @(posedge clk) disable iff (rst)
            (SKID == 2) && (cnt_q <= 2'd2) && (occ <= 3'd2);
    endproperty
    aOccupancy: assert property (pOccupancy);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural 512x40 FIFO model.
// Word-counter checks are compiled only when FIFO_RDR_WORD_COUNT_EN is defined.
module tb_fifo_stream_reader;

   localparam int DW = 40;

   logic          clk = 1'b0;
   logic          rst;
   logic          clr;
   logic          fifoClr;
   logic          fifoEmpty;
   logic          fifoRe;
   logic [DW-1:0] fifoDout;
   logic          mValid;
   logic          mReady;
   logic [DW-1:0] mData;
   logic          busy;
`ifdef FIFO_RDR_WORD_COUNT_EN
   logic [31:0]   wordCnt;
`endif

   logic          wrEn;
   logic [DW-1:0] wrData;
   logic [DW-1:0] mem [512];
   logic [8:0]    wp, rp;
   logic [9:0]    fifoCount;

   int            total = 0;
   int            bad = 0;
   int            reCount = 0;
   int            cycleIdx = 0;
   int            issuedSince = 0;
   int            xferSince = 0;
   logic          mReadyNext = 1'b0;
   logic          clrNext = 1'b0;
   logic          toggleMode = 1'b0;
   logic [DW-1:0] wq [$];
   logic [DW-1:0] rxQ [$];
   int            rxCyc [$];

   fifo_stream_reader #(.DW(DW), .SKID(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .fifo_clr   (fifoClr),
      .fifo_empty (fifoEmpty),
      .fifo_re    (fifoRe),
      .fifo_dout  (fifoDout),
      .m_valid    (mValid),
      .m_ready    (mReady),
      .m_data     (mData),
      .busy       (busy)
`ifdef FIFO_RDR_WORD_COUNT_EN
      ,
      .word_cnt   (wordCnt)
`endif
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Behavioural synchronous FIFO: registered read data, combinational empty.
   assign fifoEmpty = (fifoCount == 10'd0);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wp        <= 9'd0;
         rp        <= 9'd0;
         fifoCount <= 10'd0;
         fifoDout  <= '0;
      end else if (fifoClr) begin
         wp        <= 9'd0;
         rp        <= 9'd0;
         fifoCount <= 10'd0;
      end else begin
         if (wrEn) begin
            mem[wp] <= wrData;
            wp      <= wp + 9'd1;
         end
         if (fifoRe) begin
            fifoDout <= mem[rp];
            rp       <= rp + 9'd1;
         end
         fifoCount <= fifoCount + 10'(wrEn) - 10'(fifoRe);
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, then sample and score.
   task automatic applyStimulus();
      int occNow;
      @(negedge clk);
      mReady = toggleMode ? ~mReady : mReadyNext;
      clr    = clrNext;
      if (wq.size() > 0) begin
         wrEn   = 1'b1;
         wrData = wq.pop_front();
      end else begin
         wrEn   = 1'b0;
      end
      #1;
      cycleIdx++;
      if (fifoRe) begin
         occNow = issuedSince - xferSince - ((mValid && mReady) ? 1 : 0);
         checkOutput("noOvercommit", 64'(occNow < 2), 64'd1);
         reCount++;
         issuedSince++;
      end
      if (mValid && mReady) begin
         rxQ.push_back(mData);
         rxCyc.push_back(cycleIdx);
         xferSince++;
      end
   endtask

   task automatic drain(input int n, input int maxSteps);
      int steps = 0;
      while (rxQ.size() < n && steps < maxSteps) begin
         applyStimulus();
         steps++;
      end
      checkOutput("drainCount", 64'(rxQ.size()), 64'(n));
   endtask

   initial begin
      rst    = 1'b1;
      clr    = 1'b0;
      mReady = 1'b0;
      wrEn   = 1'b0;
      wrData = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rstValid", 64'(mValid), 64'd0);
      checkOutput("rstRe",    64'(fifoRe), 64'd0);
      checkOutput("rstData",  64'(mData),  64'd0);
      checkOutput("rstBusy",  64'(busy),   64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("idleBusy", 64'(busy), 64'd0);

      // Streaming 1..5 with continuous ready.
      $display("[TB] streaming five words");
      mReadyNext = 1'b1;
      for (int i = 1; i <= 5; i++) wq.push_back(DW'(i));
      for (int s = 0; s < 10; s++) begin
         applyStimulus();
         checkOutput($sformatf("t1Re%0d", s),    64'(fifoRe), 64'((s >= 1 && s <= 5) ? 1 : 0));
         checkOutput($sformatf("t1Valid%0d", s), 64'(mValid), 64'((s >= 3 && s <= 7) ? 1 : 0));
         if (s >= 3 && s <= 7)
            checkOutput($sformatf("t1Data%0d", s), 64'(mData), 64'(s - 2));
      end
      checkOutput("t1Count", 64'(rxQ.size()), 64'd5);
      checkOutput("t1Busy",  64'(busy), 64'd0);

      // Backpressure: ten words with ready low, then release.
      $display("[TB] backpressure");
      rxQ.delete();
      rxCyc.delete();
      reCount    = 0;
      mReadyNext = 1'b0;
      for (int i = 0; i < 10; i++) wq.push_back(40'hA0_0000_0000 + DW'(i));
      for (int s = 0; s < 14; s++) begin
         applyStimulus();
         if (s >= 8) begin
            checkOutput($sformatf("t2Valid%0d", s), 64'(mValid), 64'd1);
            checkOutput($sformatf("t2Hold%0d", s),  64'(mData),  64'h00A0_0000_0000);
         end
      end
      checkOutput("t2Pops", 64'(reCount), 64'd2);
      mReadyNext = 1'b1;
      drain(10, 40);
      for (int i = 0; i < 10; i++)
         if (i < rxQ.size())
            checkOutput($sformatf("t2Order%0d", i), 64'(rxQ[i]), 64'(40'hA0_0000_0000 + DW'(i)));
      if (rxQ.size() == 10)
         checkOutput("t2NoGaps", 64'(rxCyc[9] - rxCyc[0]), 64'd9);

      // Ready toggling every cycle over twenty words.
      $display("[TB] toggling ready");
      rxQ.delete();
      rxCyc.delete();
      toggleMode = 1'b1;
      for (int i = 0; i < 20; i++) wq.push_back(40'hB0_0000_0000 + DW'(i * 3));
      drain(20, 200);
      toggleMode = 1'b0;
      for (int i = 0; i < 20; i++)
         if (i < rxQ.size())
            checkOutput($sformatf("t3Order%0d", i), 64'(rxQ[i]), 64'(40'hB0_0000_0000 + DW'(i * 3)));
      mReadyNext = 1'b1;
      repeat (4) applyStimulus();
      checkOutput("t3Extra", 64'(rxQ.size()), 64'd20);
      checkOutput("t3Busy",  64'(busy), 64'd0);

      // Clear with one word held and one read in flight.
      $display("[TB] synchronous clear");
      rxQ.delete();
      rxCyc.delete();
      reCount    = 0;
      mReadyNext = 1'b0;
      for (int i = 0; i < 4; i++) wq.push_back(40'hC0_0000_0000 + DW'(i));
      for (int s = 0; s < 20 && reCount < 2; s++) applyStimulus();
      checkOutput("t4Pops", 64'(reCount), 64'd2);
      clrNext = 1'b1;
      applyStimulus();
      checkOutput("t4FifoClr",  64'(fifoClr), 64'd1);
      checkOutput("t4ReInClr",  64'(fifoRe),  64'd0);
      checkOutput("t4ValidPre", 64'(mValid),  64'd1);
      clrNext     = 1'b0;
      issuedSince = 0;
      xferSince   = 0;
      applyStimulus();
      checkOutput("t4ValidPost", 64'(mValid),    64'd0);
      checkOutput("t4FifoClr0",  64'(fifoClr),   64'd0);
      checkOutput("t4Empty",     64'(fifoEmpty), 64'd1);
      wq.push_back(40'h00_0000_00AA);
      wq.push_back(40'h00_0000_00BB);
      mReadyNext = 1'b1;
      drain(2, 20);
      if (rxQ.size() >= 2) begin
         checkOutput("t4First",  64'(rxQ[0]), 64'hAA);
         checkOutput("t4Second", 64'(rxQ[1]), 64'hBB);
      end
      repeat (6) applyStimulus();
      checkOutput("t4Extra", 64'(rxQ.size()), 64'd2);

      // Reset mid-stream of eight words.
      $display("[TB] reset mid-stream");
      rxQ.delete();
      rxCyc.delete();
      for (int i = 0; i < 8; i++) wq.push_back(40'hD0_0000_0000 + DW'(i));
      repeat (5) applyStimulus();
      checkOutput("t5ValidPre", 64'(mValid), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      wq.delete();
      wrEn = 1'b0;
      #1;
      checkOutput("t5RstValid", 64'(mValid), 64'd0);
      checkOutput("t5RstRe",    64'(fifoRe), 64'd0);
      checkOutput("t5RstData",  64'(mData),  64'd0);
      @(negedge clk);
      rst         = 1'b0;
      issuedSince = 0;
      xferSince   = 0;
      #1;
      checkOutput("t5BusyPost", 64'(busy), 64'd0);
      rxQ.delete();
      repeat (3) applyStimulus();
      checkOutput("t5ValidPost", 64'(mValid),     64'd0);
      checkOutput("t5NoWords",   64'(rxQ.size()), 64'd0);
      checkOutput("t5BusyIdle",  64'(busy),       64'd0);

`ifdef FIFO_RDR_WORD_COUNT_EN
      // Transfer counter: 512 words, then wrap from all-ones.
      $display("[TB] word counter");
      rxQ.delete();
      for (int i = 0; i < 512; i++) wq.push_back(DW'(i));
      drain(512, 2000);
      repeat (4) applyStimulus();
      checkOutput("wcount512", 64'(wordCnt), 64'd512);
      @(negedge clk);
      force dut.word_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.word_cnt_q;
      rxQ.delete();
      wq.push_back(40'h00_0000_0077);
      drain(1, 20);
      repeat (2) applyStimulus();
      checkOutput("wcountWrap", 64'(wordCnt), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
